// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access arbiter.
//   DATA_W / ADDR_W / DEPTH : word width, address width, implemented words
//   state_t                 : access sequencer states
//   PORT_A / PORT_B         : requester ids (CPU load/store, debug/loader)
package dmem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 64;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    ACCESS,
    DONE
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, reset : clock, async active-low reset
//   req[1:0]   : request vector, bit 0 = port A, bit 1 = port B
//   update     : strobe, advance the pointer past the current winner
//   gnt[1:0]   : one-hot grant (combinational)
// The pointer resets to favour A on a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic favour_b;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = favour_b ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // After A is served B is favoured, and vice versa.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      favour_b <= 1'b0;
    end else if (update && (gnt != 2'b00)) begin
      favour_b <= gnt[0];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single port of the 64-word data memory between the CPU
// load/store stage (A) and the debug/loader port (B).
//   clk, reset            : clock, async active-low reset
//   a_* / b_*             : req/we/addr/wdata in; gnt/done pulses, rdata/err out
//   mem_addr, mem_din     : memory address / write data (held from the latch)
//   mem_wea               : memory write enable, only ever high in ACCESS
//   mem_dout              : memory read data, captured at the end of ACCESS
//
// state  | meaning
// IDLE   | waiting for a request; arbitrate and latch the winner
// ADDR   | address/data presented to memory, grant pulse to winner
// ACCESS | write strobe or read capture (in-range addresses only)
// DONE   | done pulse with read data / error to winner
module dmem_arbiter
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wea,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [ADDR_W-1:0] DEPTH_ADDR = ADDR_W'(DEPTH);

  state_t            state, state_nxt;
  logic              win_id;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        arb_gnt;
  logic              arb_update;
  logic              in_range;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({b_req, a_req}),
    .update (arb_update),
    .gnt    (arb_gnt)
  );

  assign in_range = (lat_addr < DEPTH_ADDR);
  assign mem_addr = lat_addr;
  assign mem_din  = lat_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs decode from registered state only, so reset clears them
  // (including mem_wea) asynchronously.
  always_comb begin
    state_nxt  = state;
    arb_update = 1'b0;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    a_done     = 1'b0;
    b_done     = 1'b0;
    a_rdata    = '0;
    b_rdata    = '0;
    a_err      = 1'b0;
    b_err      = 1'b0;
    mem_wea    = 1'b0;
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          arb_update = 1'b1;
          state_nxt  = ADDR;
        end
      end
      ADDR: begin
        a_gnt     = (win_id == PORT_A);
        b_gnt     = (win_id == PORT_B);
        state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_wea   = lat_we && in_range;
        state_nxt = DONE;
      end
      DONE: begin
        a_done    = (win_id == PORT_A);
        b_done    = (win_id == PORT_B);
        a_rdata   = (win_id == PORT_A) ? rdata_q : '0;
        b_rdata   = (win_id == PORT_B) ? rdata_q : '0;
        a_err     = (win_id == PORT_A) && !in_range;
        b_err     = (win_id == PORT_B) && !in_range;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_id    <= PORT_A;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      if (arb_update) begin
        win_id    <= arb_gnt[1] ? PORT_B : PORT_A;
        lat_we    <= arb_gnt[1] ? b_we : a_we;
        lat_addr  <= arb_gnt[1] ? b_addr : a_addr;
        lat_wdata <= arb_gnt[1] ? b_wdata : a_wdata;
      end
      // Writes and out-of-range reads return zero data.
      if (state == ACCESS) begin
        rdata_q <= (!lat_we && in_range) ? mem_dout : '0;
      end
    end
  end

endmodule
